// File: rtl/regfile_2r1w.sv
// RV32I register file: 1 write, 2 registered read ports, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-first forwarding on read/write collisions.
module regfile_2r1w #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rd_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] w_val;
  logic [WIDTH-1:0]            w_rd1;
  logic [WIDTH-1:0]            w_rd2;
  logic [WIDTH-1:0]            r_rs1;
  logic [WIDTH-1:0]            r_rs2;
  logic                        r_valid;

  assign w_val[0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_ent
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_q <= '0;
      else if (wr_en && wr_addr == ADDR_W'(g))
        r_q <= wr_data;
    end

    assign w_val[g] = r_q;
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wr_live;
  assign w_wr_live = wr_en && (wr_addr != '0);

  // Each port forwards on its own; x0 never matches a live write.
  always_comb begin
    w_rd1 = w_val[rs1_addr];
    w_rd2 = w_val[rs2_addr];
    if (w_wr_live && rs1_addr == wr_addr)
      w_rd1 = wr_data;
    if (w_wr_live && rs2_addr == wr_addr)
      w_rd2 = wr_data;
  end
`else
  assign w_rd1 = w_val[rs1_addr];
  assign w_rd2 = w_val[rs2_addr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_valid <= 1'b0;
    end else if (rd_en) begin
      r_rs1   <= w_rd1;
      r_rs2   <= w_rd2;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign rs1_data = r_rs1;
  assign rs2_data = r_rs2;
  assign rd_valid = r_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w; honours REGFILE_BYPASS_EN like the DUT.
module tb_regfile_2r1w;

  typedef struct {
    logic        v;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_valid;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] model [32];
  logic [31:0] last1;
  logic [31:0] last2;
  exp_t        sb [$];

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(32), .DEPTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_valid (rd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mval(input logic [4:0] a, input logic we,
                                       input logic [4:0] wa,
                                       input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == a) return wd;
`endif
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    last1 = 32'd0;
    last2 = 32'd0;
    sb.delete();
  endtask

  task automatic cycle(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    exp_t o;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rs1_addr = a1; rs2_addr = a2;
    if (re) begin
      last1 = mval(a1, we, wa, wd);
      last2 = mval(a2, we, wa, wd);
    end
    e.v = re; e.d1 = last1; e.d2 = last2;
    sb.push_back(e);
    if (we && wa != 5'd0) model[wa] = wd;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, o.v});
      chk("rs1_data", rs1_data, o.d1);
      chk("rs2_data", rs2_data, o.d2);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_rs2", rs2_data, 32'd0);
    chk("rst_vld", {31'd0, rd_valid}, 32'd0);
    model_clear();
    @(negedge clk);
    chk("rst_hold", rs1_data | rs2_data, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
    model_clear();
    #1;
    chk("init_rs1", rs1_data, 32'd0);
    chk("init_vld", {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset clears a stored value asynchronously
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd5, 5'd5);
    do_reset();
    cycle(0, 5'd0, 32'd0, 1, 5'd5, 5'd5);

    // x0 immutability
    cycle(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd0, 5'd0);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);

    // basic write/read incl. top entry
    cycle(1, 5'd1, 32'h00000011, 0, 5'd0, 5'd0);
    cycle(1, 5'd31, 32'hA5A5A5A5, 0, 5'd0, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd1, 5'd31);

    // collision on x7
    cycle(1, 5'd7, 32'h1, 0, 5'd0, 5'd0);
    cycle(1, 5'd7, 32'h2, 1, 5'd7, 5'd7);
    cycle(0, 5'd0, 32'd0, 1, 5'd7, 5'd1);

    // handshake/hold pattern
    for (int i = 1; i <= 5; i++)
      cycle(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd1, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd2, 5'd0);
    cycle(0, 5'd0, 32'd0, 0, 5'd3, 5'd0);
    cycle(0, 5'd0, 32'd0, 0, 5'd4, 5'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd5, 5'd0);

    // random traffic with a mid-run reset
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) do_reset();
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

General-purpose register file for the RV32I core: one write port, two read ports, WIDTH-bit entries, DEPTH entries. Entry 0 is hardwired to zero (x0). Reads are registered with a one-cycle request/valid handshake, so the decode stage receives operands on a clean register boundary. All entries are built from the team's async-reset, write-enabled register primitive, widened to WIDTH.

## Interface
Parameters:
- WIDTH, 32, bits per register entry.
- DEPTH, 32, number of entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe, sampled at posedge clk.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  WIDTH  data to write.
- rd_en  input  1  read request, sampled at posedge clk.
- rs1_addr  input  ADDR_W  source 1 index, sampled with rd_en.
- rs2_addr  input  ADDR_W  source 2 index, sampled with rd_en.
- rs1_data  output  WIDTH  registered source 1 operand.
- rs2_data  output  WIDTH  registered source 2 operand.
- rd_valid  output  1  high for exactly the cycle after each accepted read.

## Operation
- Storage: DEPTH-1 physical WIDTH-bit registers for indices 1..DEPTH-1. Index 0 has no storage.
- Write: at posedge clk with wr_en=1 and wr_addr!=0, entry[wr_addr] <= wr_data. A write with wr_addr==0 is discarded with no side effect.
- Read: at posedge clk with rd_en=1:
  - rs1_data <= value(rs1_addr), rs2_data <= value(rs2_addr), rd_valid <= 1.
  - value(0) is always 0.
- Idle: at posedge clk with rd_en=0, rd_valid <= 0. rs1_data and rs2_data hold their last values.
- Both read ports are independent. rs1_addr==rs2_addr is legal and returns identical data.
- Read/write collision (rd_en=1, wr_en=1, rs*_addr==wr_addr!=0 on the same edge) is governed by the Configuration section.
- Reset (rst=1, any time, asynchronous):
  - Every entry is cleared to 0.
  - rs1_data=0, rs2_data=0, rd_valid=0.
  - A read or write in flight on the reset edge is lost.
  - Outputs hold 0 while rst is high. Operation resumes on the first posedge after rst deasserts.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable by a read issued at edge N+1, which returns it after edge N+1.
- Read latency: 1 cycle. The request is sampled at edge N; data and rd_valid are valid after edge N and stay stable until edge N+1.
- Back-to-back reads: rd_en held high gives rd_valid high continuously, with new data every cycle.
- No combinational path from any input to any output.
- Reset deassertion is released synchronously to clk by the upstream reset synchronizer. This block adds none.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: on a read/write collision, the read port returns wr_data (write-first forwarding). This applies per port, so rs1 and rs2 each bypass independently. wr_addr==0 never bypasses, and rs=0 still reads 0.
- Undefined: on a collision, the read port returns the pre-write contents (read-first). The written value appears on the next read. No bypass mux is instantiated.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst mid-cycle. Required: rs1_data=rs2_data=0 and rd_valid=0 immediately, without waiting for a clock edge. A subsequent read of x5 returns 0.
- x0 immutability: write 0xFFFFFFFF to x0, then read rs1=0, rs2=0. Required: both return 0 and rd_valid=1 for one cycle.
- Basic write/read: write x1=0x00000011 and x31=0xA5A5A5A5, then read rs1=1, rs2=31. Required: 0x00000011 and 0xA5A5A5A5 one cycle after the request.
- Collision: x7=0x1 holds, then wr_en=1 (x7<=0x2) with rd_en=1 (rs1=7) on the same edge.
  - Required with REGFILE_BYPASS_EN: rs1_data=0x2.
  - Required without it: rs1_data=0x1, and the next read returns 0x2.
- Handshake/hold: rd_en pattern 1,1,0,0,1 with rs1 stepping x1..x5. Required: rd_valid pattern 1,1,0,0,1 one cycle later. Data holds the x2 value during both idle cycles.
- Random: 10,000 cycles of random wr_en, rd_en, addresses and data, checked against a behavioural model. rst is asserted at cycle 5,000. Required: zero mismatches.
